// File: rtl/counter_sched.sv
// Two-channel event scheduler: queues single-cycle requests per channel and
// round-robins them onto a shared counter, with run/pause/clear sequencing.
module counter_sched #(
  parameter int PEND_W  = 3,
  parameter int CLR_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Clear,
  input  logic              Req0,
  input  logic              Req1,
  output logic              CntEn,
  output logic              CntSlt,
  output logic              CntReset,
  output logic [1:0]        State,
  output logic [PEND_W-1:0] Pend0,
  output logic [PEND_W-1:0] Pend1,
  output logic              Ovf0,
  output logic              Ovf1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CW-1:0]     CLR_LAST = CW'(CLR_CYC - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     clr_cnt, clr_cnt_nxt;
  logic              rr, rr_nxt;  // 0 = ch0 preferred when both pending
  logic [PEND_W-1:0] pend0_nxt, pend1_nxt;
  logic              ovf0_nxt, ovf1_nxt;
  logic              cnt_en_nxt, cnt_slt_nxt, cnt_reset_nxt;
  logic              grant0, grant1, accept;
  logic              req0_in, req1_in;

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    rr_nxt        = rr;
    grant0        = 1'b0;
    grant1        = 1'b0;
    accept        = 1'b0;
    cnt_reset_nxt = 1'b0;
    pend0_nxt     = Pend0;
    pend1_nxt     = Pend1;
    ovf0_nxt      = Ovf0;
    ovf1_nxt      = Ovf1;
    req0_in       = 1'b0;
    req1_in       = 1'b0;

    case (state)
      IDLE: begin
        if (Clear)      state_nxt = CLEAR;
        else if (Start) state_nxt = RUN;
      end
      RUN: begin
        accept = 1'b1;
        if (Clear)     state_nxt = CLEAR;
        else if (Stop) state_nxt = PAUSE;
        else if ((|Pend0) && (|Pend1)) begin
          grant0 = ~rr;
          grant1 = rr;
          rr_nxt = ~rr;
        end else if (|Pend0) begin
          grant0 = 1'b1;
          rr_nxt = 1'b1;
        end else if (|Pend1) begin
          grant1 = 1'b1;
          rr_nxt = 1'b0;
        end
      end
      PAUSE: begin
        accept = 1'b1;
        if (Clear)      state_nxt = CLEAR;
        else if (Start) state_nxt = RUN;
      end
      default: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt = IDLE;
        end else begin
          clr_cnt_nxt   = clr_cnt + CW'(1);
          cnt_reset_nxt = 1'b1;
        end
      end
    endcase

    // The edge that samples Clear already starts the counter-clear pulse.
    if (state != CLEAR && state_nxt == CLEAR) begin
      clr_cnt_nxt   = '0;
      cnt_reset_nxt = 1'b1;
    end

    req0_in = accept & Req0;
    req1_in = accept & Req1;

    if (state_nxt == CLEAR) begin
      pend0_nxt = '0;
      pend1_nxt = '0;
      ovf0_nxt  = 1'b0;
      ovf1_nxt  = 1'b0;
    end else begin
      if (req0_in && !grant0) begin
        if (Pend0 == PEND_MAX) ovf0_nxt = 1'b1;
        else                   pend0_nxt = Pend0 + PEND_W'(1);
      end else if (!req0_in && grant0) begin
        pend0_nxt = Pend0 - PEND_W'(1);
      end
      if (req1_in && !grant1) begin
        if (Pend1 == PEND_MAX) ovf1_nxt = 1'b1;
        else                   pend1_nxt = Pend1 + PEND_W'(1);
      end else if (!req1_in && grant1) begin
        pend1_nxt = Pend1 - PEND_W'(1);
      end
    end

    cnt_en_nxt  = grant0 | grant1;
    cnt_slt_nxt = grant1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      rr       <= 1'b0;
      Pend0    <= '0;
      Pend1    <= '0;
      Ovf0     <= 1'b0;
      Ovf1     <= 1'b0;
      CntEn    <= 1'b0;
      CntSlt   <= 1'b0;
      CntReset <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      rr       <= rr_nxt;
      Pend0    <= pend0_nxt;
      Pend1    <= pend1_nxt;
      Ovf0     <= ovf0_nxt;
      Ovf1     <= ovf1_nxt;
      CntEn    <= cnt_en_nxt;
      CntSlt   <= cnt_slt_nxt;
      CntReset <= cnt_reset_nxt;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus random traffic, every cycle
// compared against a queue-level reference model of the scheduler.
module tb_counter_sched;
  localparam int PEND_W  = 3;
  localparam int CLR_CYC = 2;
  localparam int MAXP    = (1 << PEND_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset, Start, Stop, Clear, Req0, Req1;
  logic              CntEn, CntSlt, CntReset;
  logic [1:0]        State;
  logic [PEND_W-1:0] Pend0, Pend1;
  logic              Ovf0, Ovf1;

  counter_sched #(.PEND_W(PEND_W), .CLR_CYC(CLR_CYC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Req0(Req0), .Req1(Req1), .CntEn(CntEn), .CntSlt(CntSlt),
    .CntReset(CntReset), .State(State), .Pend0(Pend0), .Pend1(Pend1),
    .Ovf0(Ovf0), .Ovf1(Ovf1)
  );

  // clock
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int dut_grants = 0;
  logic [0:0] exp_q[$];

  // reference model: 0=IDLE 1=RUN 2=PAUSE 3=CLEAR
  int m_state = 0, m_rr = 0, m_clr_left = 0;
  int m_pend[2] = '{0, 0};
  int m_ovf[2]  = '{0, 0};
  int m_en = 0, m_slt = 0, m_crst = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    int req[2];
    int n;
    req[0] = int'(Req0);
    req[1] = int'(Req1);
    if (Reset) begin
      m_state = 0; m_rr = 0; m_clr_left = 0;
      m_pend = '{0, 0}; m_ovf = '{0, 0};
      m_en = 0; m_slt = 0; m_crst = 0;
      return;
    end
    if (m_state == 3) begin
      m_clr_left--;
      m_crst = (m_clr_left > 0) ? 1 : 0;
      if (m_clr_left == 0) m_state = 0;
      m_en = 0; m_slt = 0;
      return;
    end
    if (Clear) begin
      m_state = 3; m_clr_left = CLR_CYC; m_crst = 1;
      m_pend = '{0, 0}; m_ovf = '{0, 0};
      m_en = 0; m_slt = 0;
      return;
    end
    g = -1;
    if (m_state == 1 && !Stop) begin
      if (m_pend[0] > 0 && m_pend[1] > 0) g = m_rr;
      else if (m_pend[0] > 0)             g = 0;
      else if (m_pend[1] > 0)             g = 1;
      if (g >= 0) m_rr = 1 - g;
    end
    for (int c = 0; c < 2; c++) begin
      n = m_pend[c] + ((m_state == 1 || m_state == 2) ? req[c] : 0) - ((g == c) ? 1 : 0);
      if (n > MAXP) begin
        n = MAXP;
        m_ovf[c] = 1;
      end
      m_pend[c] = n;
    end
    m_en   = (g >= 0) ? 1 : 0;
    m_slt  = (g == 1) ? 1 : 0;
    m_crst = 0;
    if (g >= 0) exp_q.push_back(1'(g));
    case (m_state)
      0: if (Start) m_state = 1;
      1: if (Stop)  m_state = 2;
      2: if (Start) m_state = 1;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("state", 32'(State), m_state);
    check("cnt_en", 32'(CntEn), m_en);
    check("cnt_slt", 32'(CntSlt), m_slt);
    check("cnt_reset", 32'(CntReset), m_crst);
    check("pend0", 32'(Pend0), m_pend[0]);
    check("pend1", 32'(Pend1), m_pend[1]);
    check("ovf0", 32'(Ovf0), m_ovf[0]);
    check("ovf1", 32'(Ovf1), m_ovf[1]);
    if (CntEn === 1'b1) begin
      dut_grants++;
      if (exp_q.size() == 0) check("sb_unexpected_grant", 32'd1, 32'd0);
      else check("sb_grant_channel", 32'(CntSlt), 32'(exp_q.pop_front()));
    end
    if (exp_q.size() != 0) begin
      check("sb_missing_grant", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic st, input logic sp,
                       input logic cl, input logic q0, input logic q1);
    Reset = rst; Start = st; Stop = sp; Clear = cl; Req0 = q0; Req1 = q1;
  endtask

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    cycle(2);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int g0;
    int rp0, rp1;
    drive(1, 0, 0, 0, 0, 0);
    #2;
    cycle(2);
    check("reset_state", 32'(State), 0);
    check("reset_cnt_en", 32'(CntEn), 0);
    drive(0, 0, 0, 0, 0, 0);

    // single request latency
    drive(0, 1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0); cycle();
    check("t1_pend0_after_req", 32'(Pend0), 1);
    drive(0, 0, 0, 0, 0, 0); cycle();
    check("t1_grant_en", 32'(CntEn), 1);
    check("t1_grant_slt", 32'(CntSlt), 0);
    check("t1_pend0_drained", 32'(Pend0), 0);
    cycle();
    check("t1_en_low", 32'(CntEn), 0);

    // alternating grants after a fresh reset
    do_reset();
    drive(0, 1, 0, 0, 0, 0); cycle();
    g0 = dut_grants;
    drive(0, 0, 0, 0, 1, 1); cycle();
    cycle();
    check("t2_first_grant_ch0", 32'(CntSlt), 0);
    cycle();
    check("t2_second_grant_ch1", 32'(CntSlt), 1);
    drive(0, 0, 0, 0, 0, 0); cycle(6);
    check("t2_grant_total", 32'(dut_grants - g0), 6);
    check("t2_pend0_end", 32'(Pend0), 0);
    check("t2_pend1_end", 32'(Pend1), 0);

    // saturation in PAUSE then drain
    drive(0, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 1); cycle(9);
    check("t3_pend1_sat", 32'(Pend1), MAXP);
    check("t3_ovf1", 32'(Ovf1), 1);
    check("t3_no_grant_paused", 32'(CntEn), 0);
    g0 = dut_grants;
    drive(0, 1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle(8);
    check("t3_drain_count", 32'(dut_grants - g0), MAXP);
    check("t3_pend1_zero", 32'(Pend1), 0);
    check("t3_ovf1_sticky", 32'(Ovf1), 1);

    // clear with all commands together
    drive(0, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0); cycle(3);
    drive(0, 1, 0, 0, 0, 0); cycle();
    check("t4_pend0_three", 32'(Pend0), 3);
    drive(0, 1, 1, 1, 1, 1); cycle();
    check("t4_state_clear", 32'(State), 3);
    check("t4_cnt_reset_1", 32'(CntReset), 1);
    check("t4_ovf1_cleared", 32'(Ovf1), 0);
    drive(0, 1, 0, 0, 1, 1); cycle();
    check("t4_cnt_reset_2", 32'(CntReset), 1);
    drive(0, 0, 0, 0, 1, 1); cycle();
    check("t4_state_idle", 32'(State), 0);
    check("t4_cnt_reset_off", 32'(CntReset), 0);

    // idle ignores requests and Stop
    drive(0, 0, 1, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 1, 1); cycle(2);
    check("t5_idle_pend0", 32'(Pend0), 0);
    check("t5_idle_state", 32'(State), 0);

    // reset mid-CLEAR, then in RUN with pending work
    drive(0, 0, 0, 1, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 0); cycle();
    check("t6_reset_in_clear", 32'(CntReset), 0);
    check("t6_state_idle", 32'(State), 0);
    drive(0, 1, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 1); cycle(5);
    drive(0, 1, 0, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 0); cycle();
    check("t6_reset_pend1", 32'(Pend1), 0);
    check("t6_reset_state", 32'(State), 0);
    drive(0, 1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 1); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    check("t6_post_reset_ch0_first", 32'(CntSlt), 0);
    cycle(3);

    // random traffic
    for (int e = 0; e < 30; e++) begin
      rp0 = $urandom_range(10, 95);
      rp1 = $urandom_range(10, 95);
      for (int i = 0; i < 80; i++) begin
        drive(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 14) == 0),
              ($urandom_range(0, 59) == 0),
              ($urandom_range(1, 100) <= rp0),
              ($urandom_range(1, 100) <= rp1));
        cycle();
      end
    end

    drive(0, 0, 0, 0, 0, 0);
    cycle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
